vec_stream_tx: RTL

//  Transmit end of the layer input stream: accepts one whole M-element input vector per handshake
//  (parallel) and emits it one T-bit element per handshake on the valid/ready stream consumed by

---
 rtl/nn_stream_pkg.sv | 16 +
 rtl/vec_stream_tx_if.sv | 24 ++
 rtl/vec_stream_tx.sv | 80 ++++++++
 3 files changed

// File: rtl/nn_stream_pkg.sv
// Shared types and helpers for the layer-side vector streaming blocks.
// Used by both the transmit (vector -> elements) and receive (elements -> vector) ends.
package nn_stream_pkg;

    localparam int ELEM_W = 16;

    typedef logic signed [ELEM_W-1:0] elem_t;

    // Element 0 sits in the least-significant T bits of a packed vector and goes out first.
    localparam bit ELEM_LSB_FIRST = 1'b1;

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vec_stream_tx_if.sv
// Host vector input (s_*) and element stream output (m_*) of the transmit block.
// The master modport is the block itself; slave is the host + downstream layer side.
interface vec_stream_tx_if #(
    parameter int T = 16,
    parameter int M = 8
);
    logic           s_valid;
    logic           s_ready;
    logic [M*T-1:0] data_in;
    logic           m_valid;
    logic           m_ready;
    logic [T-1:0]   data_out;
    logic           m_last;

    modport master (
        input  s_valid, data_in, m_ready,
        output s_ready, m_valid, data_out, m_last
    );

    modport slave (
        output s_valid, data_in, m_ready,
        input  s_ready, m_valid, data_out, m_last
    );
endinterface

// File: rtl/vec_stream_tx.sv
// Splits whole M-element vectors into a T-bit element stream; element 0 valid the cycle after accept.
// Active + pending slots give gap-free streaming; s_ready falls only when both slots hold a vector.
module vec_stream_tx
    import nn_stream_pkg::*;
#(
    parameter int T = 16,
    parameter int M = 8
) (
    input  logic             clk,
    input  logic             reset,
    vec_stream_tx_if.master  bus
);

    localparam int             IW   = idx_width(M);
    localparam logic [IW-1:0]  LAST = IW'(M - 1);

    logic [M*T-1:0] act_vec;
    logic [M*T-1:0] pend_vec;
    logic           act_full;
    logic           pend_full;
    logic [IW-1:0]  idx;
    logic [T-1:0]   elem_sel;

    logic s_ready_int;
    logic s_hs;
    logic m_hs;
    logic vec_done;

    // s_ready depends on registered state (and reset) only, never on m_ready.
    assign s_ready_int = reset && !pend_full;
    assign s_hs        = bus.s_valid && s_ready_int;
    assign m_hs        = act_full && bus.m_ready;
    assign vec_done    = m_hs && (idx == LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            act_vec   <= '0;
            pend_vec  <= '0;
            act_full  <= 1'b0;
            pend_full <= 1'b0;
            idx       <= '0;
        end else begin
            if (m_hs) begin
                idx <= (idx == LAST) ? '0 : idx + 1'b1;
            end

            if (vec_done) begin
                // Pending vector has priority; a same-cycle accept only happens with pend empty.
                if (pend_full) begin
                    act_vec   <= pend_vec;
                    pend_full <= 1'b0;
                end else if (s_hs) begin
                    act_vec <= bus.data_in;
                end else begin
                    act_full <= 1'b0;
                end
            end else if (s_hs) begin
                if (!act_full) begin
                    act_vec  <= bus.data_in;
                    act_full <= 1'b1;
                end else begin
                    pend_vec  <= bus.data_in;
                    pend_full <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        int sel;
        sel      = ELEM_LSB_FIRST ? int'(idx) : (M - 1 - int'(idx));
        elem_sel = act_vec[sel*T +: T];
    end

    assign bus.s_ready  = s_ready_int;
    assign bus.m_valid  = act_full;
    assign bus.data_out = elem_sel;
    assign bus.m_last   = act_full && (idx == LAST);

endmodule
